// File: rtl/mlp_seq.sv
// rtl/mlp_seq.sv - time-multiplexed two-layer MLP engine with one shared signed MAC
//
// Purpose: computes dout = clamp(W2 * act(W1 * din + b1) + b2) in Q(DW-FRAC).FRAC
// fixed point. One neuron is computed at a time: one MAC cycle per tap, then one
// finalize cycle that adds the bias, rescales, saturates (and applies ReLU to hidden).
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  input handshake; din_i latched on acceptance
//   din_i [N_IN]           input features
//   w1_i/b1_i, w2_i/b2_i   layer weights/biases, held stable by the upstream
//                          from acceptance until out_valid_o
//   out_valid_o/out_ready_i output handshake
//   dout_o [N_OUT]         registered results
//   busy_o                 engine is computing or holding a result
module mlp_seq #(
  parameter int N_IN     = 6,
  parameter int N_HID    = 16,
  parameter int N_OUT    = 3,
  parameter int DW       = 8,
  parameter int ACC_W    = 24,
  parameter int FRAC     = 4,
  parameter int RELU_HID = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic signed [DW-1:0] din_i [N_IN],
  input  logic signed [DW-1:0] w1_i  [N_IN][N_HID],
  input  logic signed [DW-1:0] b1_i  [N_HID],
  input  logic signed [DW-1:0] w2_i  [N_HID][N_OUT],
  input  logic signed [DW-1:0] b2_i  [N_OUT],
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic signed [DW-1:0] dout_o [N_OUT],
  output logic                 busy_o
);

  localparam int MAX_TAP = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int MAX_NRN = (N_HID > N_OUT) ? N_HID : N_OUT;
  // The tap counter must also reach MAX_TAP, which marks the finalize cycle.
  localparam int TW      = $clog2(MAX_TAP + 1);
  localparam int NW      = (MAX_NRN > 1) ? $clog2(MAX_NRN) : 1;
  localparam int IW_IN   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int IW_HID  = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int IW_OUT  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [TW-1:0] TAP_L1      = TW'(N_IN);
  localparam logic [TW-1:0] TAP_L2      = TW'(N_HID);
  localparam logic [NW-1:0] NRN_L1_LAST = NW'(N_HID - 1);
  localparam logic [NW-1:0] NRN_L2_LAST = NW'(N_OUT - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L2   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           tap_q, tap_d;
  logic [NW-1:0]           nrn_q, nrn_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DW-1:0]    x_q    [N_IN];
  logic signed [DW-1:0]    x_d    [N_IN];
  logic signed [DW-1:0]    h_q    [N_HID];
  logic signed [DW-1:0]    h_d    [N_HID];
  logic signed [DW-1:0]    dout_q [N_OUT];
  logic signed [DW-1:0]    dout_d [N_OUT];

  // Shared datapath operands.
  logic signed [DW-1:0]    mul_a, mul_b, bias;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext, bias_sh, sum, scaled;
  logic signed [DW-1:0]    sat_val, hid_val;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    bias  = '0;
    if (state_q == S_L1) begin
      bias = b1_i[nrn_q[IW_HID-1:0]];
      // Operands are gated off in the finalize cycle, where tap_q is past the array.
      if (tap_q != TAP_L1) begin
        mul_a = x_q[tap_q[IW_IN-1:0]];
        mul_b = w1_i[tap_q[IW_IN-1:0]][nrn_q[IW_HID-1:0]];
      end
    end else if (state_q == S_L2) begin
      bias = b2_i[nrn_q[IW_OUT-1:0]];
      if (tap_q != TAP_L2) begin
        mul_a = h_q[tap_q[IW_HID-1:0]];
        mul_b = w2_i[tap_q[IW_HID-1:0]][nrn_q[IW_OUT-1:0]];
      end
    end
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  // Bias is an integer-aligned Q value, so it joins the accumulator at the
  // product's scale (2*FRAC fractional bits) before the single rescale shift.
  assign bias_sh  = {{(ACC_W-DW){bias[DW-1]}}, bias} <<< FRAC;
  assign sum      = acc_q + bias_sh;
  assign scaled   = sum >>> FRAC;

  always_comb begin
    if (scaled > SAT_MAX) begin
      sat_val = SAT_MAX[DW-1:0];
    end else if (scaled < SAT_MIN) begin
      sat_val = SAT_MIN[DW-1:0];
    end else begin
      sat_val = scaled[DW-1:0];
    end
    hid_val = ((RELU_HID != 0) && sat_val[DW-1]) ? '0 : sat_val;
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    nrn_d       = nrn_q;
    acc_d       = acc_q;
    x_d         = x_q;
    h_d         = h_q;
    dout_d      = dout_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          x_d     = din_i;
          tap_d   = '0;
          nrn_d   = '0;
          acc_d   = '0;
          state_d = S_L1;
        end
      end
      S_L1: begin
        if (tap_q != TAP_L1) begin
          acc_d = acc_q + prod_ext;
          tap_d = tap_q + TW'(1);
        end else begin
          h_d[nrn_q[IW_HID-1:0]] = hid_val;
          acc_d = '0;
          tap_d = '0;
          if (nrn_q == NRN_L1_LAST) begin
            nrn_d   = '0;
            state_d = S_L2;
          end else begin
            nrn_d = nrn_q + NW'(1);
          end
        end
      end
      S_L2: begin
        if (tap_q != TAP_L2) begin
          acc_d = acc_q + prod_ext;
          tap_d = tap_q + TW'(1);
        end else begin
          dout_d[nrn_q[IW_OUT-1:0]] = sat_val;
          acc_d = '0;
          tap_d = '0;
          if (nrn_q == NRN_L2_LAST) begin
            nrn_d   = '0;
            state_d = S_DONE;
          end else begin
            nrn_d = nrn_q + NW'(1);
          end
        end
      end
      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      nrn_q   <= '0;
      acc_q   <= '0;
      for (int i = 0; i < N_IN; i++)  x_q[i]    <= '0;
      for (int i = 0; i < N_HID; i++) h_q[i]    <= '0;
      for (int i = 0; i < N_OUT; i++) dout_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      nrn_q   <= nrn_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      h_q     <= h_d;
      dout_q  <= dout_d;
    end
  end

  assign dout_o = dout_q;
  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_mlp_seq.sv
// tb/tb_mlp_seq.sv - scoreboard testbench for mlp_seq
module tb_mlp_seq;

  localparam int N_IN  = 6;
  localparam int N_HID = 16;
  localparam int N_OUT = 3;
  localparam int DW    = 8;
  localparam int LAT   = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [DW-1:0] din  [N_IN];
  logic signed [DW-1:0] w1   [N_IN][N_HID];
  logic signed [DW-1:0] b1   [N_HID];
  logic signed [DW-1:0] w2   [N_HID][N_OUT];
  logic signed [DW-1:0] b2   [N_OUT];
  logic signed [DW-1:0] dout [N_OUT];

  always #5 clk = ~clk;

  mlp_seq #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW),
    .ACC_W(24), .FRAC(4), .RELU_HID(1)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .din_i(din), .w1_i(w1), .b1_i(b1), .w2_i(w2), .b2_i(b2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .dout_o(dout), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q [$];

  function automatic logic [23:0] got3();
    return {dout[2], dout[1], dout[0]};
  endfunction

  function automatic logic [23:0] exp3(input int d0, input int d1, input int d2);
    return {d2[7:0], d1[7:0], d0[7:0]};
  endfunction

  // Monitor: every output handshake pops one expected vector.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [23:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected got %h with empty scoreboard", got3());
      end else begin
        e = exp_q.pop_front();
        if (got3() !== e) begin
          errors++;
          $display("FAIL dout got %h expected %h", got3(), e);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_all(input int dv, input int w1v, input int b1v, input int w2v,
                         input int b20, input int b21, input int b22);
    for (int i = 0; i < N_IN; i++) din[i] = dv[7:0];
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_HID; j++) w1[i][j] = w1v[7:0];
    for (int j = 0; j < N_HID; j++) b1[j] = b1v[7:0];
    for (int j = 0; j < N_HID; j++)
      for (int k = 0; k < N_OUT; k++) w2[j][k] = w2v[7:0];
    b2[0] = b20[7:0];
    b2[1] = b21[7:0];
    b2[2] = b22[7:0];
  endtask

  // Raises in_valid and returns the number of edges until the accepting edge.
  task automatic accept(output int edges);
    logic r;
    in_valid = 1'b1;
    edges = 0;
    do begin
      r = in_ready;
      @(posedge clk); #1;
      edges++;
    end while (!r && edges < 400);
    if (!r) begin
      errors++;
      $display("FAIL accept_timeout after %0d edges", edges);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid && edges < 1000) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run(input string name, input logic [23:0] e);
    int n;
    exp_q.push_back(e);
    accept(n);
    wait_out(n);
    chk({name, "_latency"}, n, LAT);
    @(posedge clk); #1;
    chk({name, "_in_ready_after"}, int'(in_ready), 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_all(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dout", int'(got3()), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);

    // Nominal: 6*16*16 = 1536 -> 96; 16*96 = 1536 -> 96.
    set_all(16, 16, 0, 1, 0, 0, 0);
    run("nominal", exp3(96, 96, 96));

    // Negative saturation: hidden clamps to 127, 16*127*-128 >> 4 = -16256 -> -128.
    set_all(127, 127, 0, -128, 0, 0, 0);
    run("sat_neg", exp3(-128, -128, -128));

    // Positive saturation under back-pressure, with in_valid pulsed in DONE.
    set_all(127, 127, 0, 127, 0, 0, 0);
    out_ready = 1'b0;
    exp_q.push_back(exp3(127, 127, 127));
    accept(n);
    wait_out(n);
    chk("bp_latency", n, LAT);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 3 || c == 4);
      @(posedge clk); #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_dout_hold", int'(got3()), int'(exp3(127, 127, 127)));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", int'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1 chk("bp_pulse_ignored_busy", int'(busy), 0);

    // ReLU and output bias: hidden -96 -> 0, dout equals b2.
    set_all(16, -16, 0, 1, 5, -3, 0);
    run("relu_bias", exp3(5, -3, 0));

    // Floor shifts: 6*3 = 18 -> 1 (positive), then -1*1 = -1 -> -1 (floor, not 0).
    set_all(3, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < N_OUT; k++) w2[0][k] = -8'sd1;
    run("floor", exp3(-1, -1, -1));

    // Back-to-back with out_ready tied high; din=8 gives 768 -> 48 in both layers.
    set_all(16, 16, 0, 1, 0, 0, 0);
    exp_q.push_back(exp3(96, 96, 96));
    accept(n);
    wait_out(n);
    chk("b2b_first_latency", n, LAT);
    for (int i = 0; i < N_IN; i++) din[i] = 8'sd8;
    exp_q.push_back(exp3(48, 48, 48));
    accept(n);
    chk("b2b_accept_gap", n, 2);
    wait_out(n);
    chk("b2b_second_latency", n, LAT);
    @(posedge clk); #1;

    // Reset mid-L1, then a biased vector:
    // (1536 + 2*16) >> 4 = 98; (16*98 + b2*16) >> 4 = 98 + b2.
    set_all(16, 16, 0, 1, 0, 0, 0);
    accept(n);
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_dout", int'(got3()), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", int'(in_ready), 1);
    set_all(16, 16, 2, 1, 1, 0, -1);
    run("post_rst", exp3(99, 98, 97));

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
